// File: rtl/level_pkg.sv
// Shared types and default parameters for the level sequencer.
package level_pkg;

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_FINALE = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } level_state_t;

  localparam int unsigned DEF_NUM_STAGES   = 7;
  localparam int unsigned DEF_STAGE_TICKS  = 130;
  localparam int unsigned DEF_FINALE_TICKS = 390;
  localparam int unsigned DEF_LIVES        = 3;
  localparam int unsigned DEF_TIMER_W      = 11;

  // Index width that never collapses to zero bits for a count of one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Handshake bundle between the sequencer, tick source, player logic and spawners.
interface level_sequencer_if #(
  parameter int unsigned NUM_STAGES = 7,
  parameter int unsigned LIVES      = 3
) ();
  import level_pkg::*;

  localparam int unsigned SW = idx_w(NUM_STAGES);
  localparam int unsigned LW = idx_w(LIVES + 1);

  logic                  tick;
  logic                  userSel;
  logic                  playerDied;
  logic                  reset_obj_count;
  logic [NUM_STAGES-1:0] shapes;
  logic [SW-1:0]         stage_idx;
  logic                  playerDone;
  logic                  menuScreen;
  logic                  winScreen;
  logic                  loseScreen;
  logic [LW-1:0]         lives_left;

  modport master (
    output tick, userSel, playerDied,
    input  reset_obj_count, shapes, stage_idx, playerDone,
           menuScreen, winScreen, loseScreen, lives_left
  );

  modport slave (
    input  tick, userSel, playerDied,
    output reset_obj_count, shapes, stage_idx, playerDone,
           menuScreen, winScreen, loseScreen, lives_left
  );
endinterface

// File: rtl/level_timer.sv
// Frame-tick counter with clear, enable and terminal-count flag against a runtime limit.
module level_timer #(
  parameter int unsigned TIMER_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_tc
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (i_en)   r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == (i_limit - 1'b1));

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: menu, staged play, finale, win/lose screens.
// Optional macro LEVEL_LIVES_EN enables lives with checkpoint restart and the LOSE path.
module level_sequencer
  import level_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
  parameter int unsigned STAGE_TICKS  = DEF_STAGE_TICKS,
  parameter int unsigned FINALE_TICKS = DEF_FINALE_TICKS,
  parameter int unsigned LIVES        = DEF_LIVES,
  parameter int unsigned TIMER_W      = DEF_TIMER_W
) (
  input  logic             clk,
  input  logic             reset_n,
  level_sequencer_if.slave bus
);

  localparam int unsigned SW = idx_w(NUM_STAGES);
  localparam int unsigned LW = idx_w(LIVES + 1);
  localparam logic [SW-1:0]      LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [TIMER_W-1:0] STAGE_LIM  = TIMER_W'(STAGE_TICKS);
  localparam logic [TIMER_W-1:0] FINALE_LIM = TIMER_W'(FINALE_TICKS);

  level_state_t  r_state, w_state_n;
  logic [SW-1:0] r_stage, w_stage_n;
  logic          r_obj, w_obj_n;
  logic          r_sel_q;
  logic          w_sel_rise;
  logic          w_t_clr, w_t_en, w_t_tc;
  logic [TIMER_W-1:0] w_limit;
`ifdef LEVEL_LIVES_EN
  logic [LW-1:0] r_lives, w_lives_n;
`endif

  assign w_sel_rise = bus.userSel & ~r_sel_q;
  assign w_limit    = (r_state == ST_FINALE) ? FINALE_LIM : STAGE_LIM;

  level_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clr   (w_t_clr),
    .i_en    (w_t_en),
    .i_limit (w_limit),
    .o_tc    (w_t_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_MENU;
      r_stage <= '0;
      r_obj   <= 1'b0;
      r_sel_q <= 1'b0;
`ifdef LEVEL_LIVES_EN
      r_lives <= LW'(LIVES);
`endif
    end else begin
      r_state <= w_state_n;
      r_stage <= w_stage_n;
      r_obj   <= w_obj_n;
      r_sel_q <= bus.userSel;
`ifdef LEVEL_LIVES_EN
      r_lives <= w_lives_n;
`endif
    end
  end

  // Death outranks a same-cycle boundary tick, so the boundary is simply dropped.
  always_comb begin
    w_state_n = r_state;
    w_stage_n = r_stage;
    w_obj_n   = 1'b0;
    w_t_clr   = 1'b0;
    w_t_en    = 1'b0;
`ifdef LEVEL_LIVES_EN
    w_lives_n = r_lives;
`endif
    unique case (r_state)
      ST_MENU: begin
        if (w_sel_rise) begin
          w_state_n = ST_PLAY;
          w_stage_n = '0;
          w_t_clr   = 1'b1;
`ifdef LEVEL_LIVES_EN
          w_lives_n = LW'(LIVES);
`endif
        end
      end
      ST_PLAY, ST_FINALE: begin
        if (bus.playerDied) begin
          w_t_clr = 1'b1;
`ifdef LEVEL_LIVES_EN
          if (r_lives > LW'(1)) begin
            w_lives_n = r_lives - 1'b1;
            w_obj_n   = 1'b1;
          end else begin
            w_lives_n = '0;
            w_state_n = ST_LOSE;
          end
`else
          w_state_n = ST_PLAY;
          w_stage_n = '0;
          w_obj_n   = 1'b1;
`endif
        end else if (bus.tick) begin
          if (w_t_tc) begin
            w_t_clr = 1'b1;
            if (r_state == ST_FINALE) begin
              w_state_n = ST_WIN;
            end else begin
              w_obj_n = 1'b1;
              if (r_stage == LAST_STAGE) w_state_n = ST_FINALE;
              else                       w_stage_n = r_stage + 1'b1;
            end
          end else begin
            w_t_en = 1'b1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (w_sel_rise) w_state_n = ST_MENU;
      end
      default: w_state_n = ST_MENU;
    endcase
  end

  always_comb begin
    bus.reset_obj_count = r_obj;
    bus.stage_idx       = r_stage;
    bus.menuScreen      = (r_state == ST_MENU);
    bus.playerDone      = (r_state == ST_FINALE) || (r_state == ST_WIN);
    bus.winScreen       = (r_state == ST_WIN);
`ifdef LEVEL_LIVES_EN
    bus.loseScreen      = (r_state == ST_LOSE);
    bus.lives_left      = r_lives;
`else
    bus.loseScreen      = 1'b0;
    bus.lives_left      = '0;
`endif
    bus.shapes = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      bus.shapes[i] = (r_state == ST_PLAY) && (r_stage == SW'(i));
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer (NUM_STAGES=3, STAGE_TICKS=4, FINALE_TICKS=2, LIVES=2).
module tb_level_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic lose_seen = 1'b0;

`ifdef LEVEL_LIVES_EN
  localparam logic [1:0] EXP_LIVES = 2'd2;
`else
  localparam logic [1:0] EXP_LIVES = 2'd0;
`endif

  always #5 clk = ~clk;

  level_sequencer_if #(.NUM_STAGES(3), .LIVES(2)) bus ();

  level_sequencer #(
    .NUM_STAGES  (3),
    .STAGE_TICKS (4),
    .FINALE_TICKS(2),
    .LIVES       (2),
    .TIMER_W     (11)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always @(posedge clk) if (bus.loseScreen === 1'b1) lose_seen <= 1'b1;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus.tick = 1'b0; bus.userSel = 1'b0; bus.playerDied = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic start_game();
    bus.userSel = 1'b1; cyc();
    bus.userSel = 1'b0; cyc();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1; cyc();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.menuScreen !== 1'b1) begin n_bad++; $display("FAIL rst_menu got %b want 1", bus.menuScreen); end
    n_cmp++; if (bus.shapes !== 3'b000) begin n_bad++; $display("FAIL rst_shapes got %b want 000", bus.shapes); end
    n_cmp++; if (bus.stage_idx !== 2'd0) begin n_bad++; $display("FAIL rst_stage got %0d want 0", bus.stage_idx); end
    n_cmp++; if (bus.lives_left !== EXP_LIVES) begin n_bad++; $display("FAIL rst_lives got %0d want %0d", bus.lives_left, EXP_LIVES); end
    n_cmp++; if ({bus.reset_obj_count, bus.playerDone, bus.winScreen, bus.loseScreen} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_flags got %b want 0000", {bus.reset_obj_count, bus.playerDone, bus.winScreen, bus.loseScreen}); end
    bus.playerDied = 1'b1; bus.tick = 1'b1; repeat (3) cyc(); bus.playerDied = 1'b0; bus.tick = 1'b0;
    n_cmp++; if (bus.menuScreen !== 1'b1) begin n_bad++; $display("FAIL menu_ignore got %b want 1", bus.menuScreen); end
  endtask

  task automatic test_sel_hold();
    int falls;
    logic prev;
    do_reset();
    falls = 0; prev = bus.menuScreen;
    bus.userSel = 1'b1;
    cyc();
    n_cmp++; if (bus.shapes !== 3'b001) begin n_bad++; $display("FAIL sel_shapes got %b want 001", bus.shapes); end
    for (int i = 0; i < 9; i++) begin
      if (prev && !bus.menuScreen) falls++;
      prev = bus.menuScreen;
      cyc();
    end
    if (prev && !bus.menuScreen) falls++;
    bus.userSel = 1'b0;
    n_cmp++; if (falls !== 1) begin n_bad++; $display("FAIL sel_once got %0d want 1", falls); end
    n_cmp++; if (bus.shapes !== 3'b001) begin n_bad++; $display("FAIL sel_stay got %b want 001", bus.shapes); end
  endtask

  task automatic test_play_to_win();
    int pulses;
    logic [2:0] exp_sh;
    do_reset(); start_game();
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      exp_sh = 3'b001 << ((k - 1) / 4);
      n_cmp++; if (bus.shapes !== exp_sh) begin n_bad++; $display("FAIL play_shapes tick%0d got %b want %b", k, bus.shapes, exp_sh); end
      do_tick();
      if (bus.reset_obj_count === 1'b1) pulses++;
      n_cmp++; if (bus.reset_obj_count !== ((k % 4) == 0)) begin
        n_bad++; $display("FAIL play_pulse tick%0d got %b want %b", k, bus.reset_obj_count, (k % 4) == 0); end
      cyc();
    end
    n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL play_npulse got %0d want 3", pulses); end
    n_cmp++; if ({bus.playerDone, bus.shapes} !== 4'b1000) begin n_bad++; $display("FAIL finale got %b want 1000", {bus.playerDone, bus.shapes}); end
    do_tick();
    n_cmp++; if (bus.winScreen !== 1'b0) begin n_bad++; $display("FAIL finale_early got %b want 0", bus.winScreen); end
    do_tick();
    n_cmp++; if ({bus.winScreen, bus.playerDone, bus.reset_obj_count} !== 3'b110) begin
      n_bad++; $display("FAIL win got %b want 110", {bus.winScreen, bus.playerDone, bus.reset_obj_count}); end
    bus.userSel = 1'b1; cyc(); bus.userSel = 1'b0;
    n_cmp++; if (bus.menuScreen !== 1'b1) begin n_bad++; $display("FAIL win_menu got %b want 1", bus.menuScreen); end
  endtask

`ifdef LEVEL_LIVES_EN
  task automatic test_death_lives();
    do_reset(); start_game();
    repeat (6) do_tick();
    bus.playerDied = 1'b1; cyc(); bus.playerDied = 1'b0;
    n_cmp++; if ({bus.lives_left, bus.stage_idx, bus.reset_obj_count} !== 5'b01_01_1) begin
      n_bad++; $display("FAIL death1 got %b want 01011", {bus.lives_left, bus.stage_idx, bus.reset_obj_count}); end
    cyc();
    n_cmp++; if (bus.reset_obj_count !== 1'b0) begin n_bad++; $display("FAIL death1_once got %b want 0", bus.reset_obj_count); end
    repeat (3) do_tick();
    n_cmp++; if (bus.stage_idx !== 2'd1) begin n_bad++; $display("FAIL death1_timer got %0d want 1", bus.stage_idx); end
    do_tick();
    n_cmp++; if (bus.stage_idx !== 2'd2) begin n_bad++; $display("FAIL death1_adv got %0d want 2", bus.stage_idx); end
    bus.playerDied = 1'b1; cyc(); bus.playerDied = 1'b0;
    n_cmp++; if ({bus.loseScreen, bus.lives_left, bus.reset_obj_count, bus.shapes} !== 7'b1_00_0_000) begin
      n_bad++; $display("FAIL lose got %b want 1000000", {bus.loseScreen, bus.lives_left, bus.reset_obj_count, bus.shapes}); end
    bus.userSel = 1'b1; cyc(); bus.userSel = 1'b0;
    n_cmp++; if ({bus.menuScreen, bus.loseScreen} !== 2'b10) begin n_bad++; $display("FAIL lose_menu got %b want 10", {bus.menuScreen, bus.loseScreen}); end
  endtask

  task automatic test_death_boundary();
    do_reset(); start_game();
    repeat (3) do_tick();
    bus.tick = 1'b1; bus.playerDied = 1'b1; cyc(); bus.tick = 1'b0; bus.playerDied = 1'b0;
    n_cmp++; if ({bus.stage_idx, bus.lives_left, bus.reset_obj_count} !== 5'b00_01_1) begin
      n_bad++; $display("FAIL dbound got %b want 00011", {bus.stage_idx, bus.lives_left, bus.reset_obj_count}); end
    cyc();
    n_cmp++; if (bus.reset_obj_count !== 1'b0) begin n_bad++; $display("FAIL dbound_once got %b want 0", bus.reset_obj_count); end
    repeat (3) do_tick();
    n_cmp++; if (bus.stage_idx !== 2'd0) begin n_bad++; $display("FAIL dbound_timer got %0d want 0", bus.stage_idx); end
  endtask
`else
  task automatic test_death_restart();
    do_reset(); start_game();
    repeat (9) do_tick();
    n_cmp++; if (bus.stage_idx !== 2'd2) begin n_bad++; $display("FAIL norst_pre got %0d want 2", bus.stage_idx); end
    bus.playerDied = 1'b1; cyc(); bus.playerDied = 1'b0;
    n_cmp++; if ({bus.stage_idx, bus.shapes, bus.reset_obj_count, bus.lives_left} !== 8'b00_001_1_00) begin
      n_bad++; $display("FAIL norst_death got %b want 00001100", {bus.stage_idx, bus.shapes, bus.reset_obj_count, bus.lives_left}); end
    repeat (3) do_tick();
    bus.tick = 1'b1; bus.playerDied = 1'b1; cyc(); bus.tick = 1'b0; bus.playerDied = 1'b0;
    n_cmp++; if ({bus.stage_idx, bus.reset_obj_count} !== 3'b00_1) begin
      n_bad++; $display("FAIL norst_bound got %b want 001", {bus.stage_idx, bus.reset_obj_count}); end
    repeat (3) do_tick();
    n_cmp++; if (bus.stage_idx !== 2'd0) begin n_bad++; $display("FAIL norst_timer got %0d want 0", bus.stage_idx); end
    do_tick();
    n_cmp++; if (bus.stage_idx !== 2'd1) begin n_bad++; $display("FAIL norst_adv got %0d want 1", bus.stage_idx); end
    repeat (8) do_tick();
    bus.playerDied = 1'b1; cyc(); bus.playerDied = 1'b0;
    n_cmp++; if ({bus.playerDone, bus.shapes} !== 4'b0001) begin
      n_bad++; $display("FAIL norst_finale got %b want 0001", {bus.playerDone, bus.shapes}); end
    n_cmp++; if (lose_seen !== 1'b0) begin n_bad++; $display("FAIL norst_lose got %b want 0", lose_seen); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset(); start_game();
    repeat (12) do_tick();
    n_cmp++; if (bus.playerDone !== 1'b1) begin n_bad++; $display("FAIL mid_finale got %b want 1", bus.playerDone); end
    #2 reset_n = 1'b0; #1;
    n_cmp++; if ({bus.menuScreen, bus.playerDone, bus.reset_obj_count} !== 3'b100) begin
      n_bad++; $display("FAIL mid_rst got %b want 100", {bus.menuScreen, bus.playerDone, bus.reset_obj_count}); end
    n_cmp++; if (bus.lives_left !== EXP_LIVES) begin n_bad++; $display("FAIL mid_lives got %0d want %0d", bus.lives_left, EXP_LIVES); end
    cyc(); reset_n = 1'b1;
  endtask

  initial begin
    bus.tick = 1'b0; bus.userSel = 1'b0; bus.playerDied = 1'b0;
    test_reset();
    test_sel_hold();
    test_play_to_win();
`ifdef LEVEL_LIVES_EN
    test_death_lives();
    test_death_boundary();
`else
    test_death_restart();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
